// File: rtl/cpu_defs.sv
// Shared CPU definitions for the iterative divider: operand width,
// divider FSM state encoding and HI/LO field positions on the product bus.
package cpu_defs;

    localparam int DATA_W = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    localparam int HI_MSB = 63;
    localparam int LO_MSB = 31;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, dividend} left, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_step
    import cpu_defs::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] dvd_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] dvd_o,
    output logic         qbit_o
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // rem < divisor always holds, so the shifted value fits in W+1 bits and
    // bit W of the trial difference is a reliable sign bit.
    always_comb begin
        shifted = {rem_i, dvd_i[W-1]};
        trial   = shifted - {1'b0, dvs_i};
        qbit_o  = ~trial[W];
        rem_o   = qbit_o ? trial[W-1:0] : shifted[W-1:0];
        dvd_o   = {dvd_i[W-2:0], qbit_o};
    end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative DIV/DIVU responder for the EXE divide handshake; returns
// {remainder, quotient} and holds it until accepted or cancelled.
module div_iter_unit
    import cpu_defs::*;
#(
    parameter int DATA_W_P = DATA_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  Unsigned,
    input  logic                  div_begin,
    input  logic [DATA_W_P-1:0]   div_op1,
    input  logic [DATA_W_P-1:0]   div_op2,
    input  logic                  div_accept,
    input  logic                  div_cancel,
    output logic [2*DATA_W_P-1:0] product,
    output logic                  div_end,
    output logic                  div_busy
);

    localparam int CNT_W = $clog2(DATA_W_P);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W_P-1:0]   rem_q, rem_d;
    logic [DATA_W_P-1:0]   dvd_q, dvd_d;
    logic [DATA_W_P-1:0]   dvs_q, dvs_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic [2*DATA_W_P-1:0] product_q, product_d;

    logic [DATA_W_P-1:0]   step_rem, step_dvd;
    logic                  step_qbit;
    logic [DATA_W_P-1:0]   op1_abs, op2_abs;
    logic                  op1_neg, op2_neg;

    div_step #(.W(DATA_W_P)) u_step (
        .rem_i  (rem_q),
        .dvd_i  (dvd_q),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .dvd_o  (step_dvd),
        .qbit_o (step_qbit)
    );

    always_comb begin
        op1_neg = ~Unsigned & div_op1[DATA_W_P-1];
        op2_neg = ~Unsigned & div_op2[DATA_W_P-1];
        op1_abs = op1_neg ? -div_op1 : div_op1;
        op2_abs = op2_neg ? -div_op2 : div_op2;
    end

    // Cancel outranks everything; a zero divisor bypasses iteration entirely.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        product_d = product_q;
        if (div_cancel) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_begin) begin
                        cnt_d  = '0;
                        rem_d  = '0;
                        dvd_d  = op1_abs;
                        dvs_d  = op2_abs;
                        qneg_d = op1_neg ^ op2_neg;
                        rneg_d = op1_neg;
                        if (div_op2 == '0) begin
                            state_d   = DIV_DONE;
                            product_d = {div_op1, {DATA_W_P{1'b1}}};
                        end else begin
                            state_d = DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_d = step_rem;
                    dvd_d = step_dvd;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W_P - 1)) begin
                        state_d   = DIV_DONE;
                        product_d = {rneg_q ? -step_rem : step_rem,
                                     qneg_q ? -step_dvd : step_dvd};
                    end
                end
                DIV_DONE: begin
                    if (div_accept) begin
                        state_d = DIV_IDLE;
                    end
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            product_q <= product_d;
        end
    end

    assign product  = product_q;
    assign div_end  = (state_q == DIV_DONE);
    assign div_busy = (state_q == DIV_BUSY) || (state_q == DIV_DONE);

    logic unused_step_qbit;
    assign unused_step_qbit = step_qbit;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: latency, signed/unsigned results,
// divide-by-zero, held results, cancel and asynchronous reset.
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        Unsigned = 1'b0;
    logic        div_begin = 1'b0;
    logic [31:0] div_op1 = '0;
    logic [31:0] div_op2 = '0;
    logic        div_accept = 1'b0;
    logic        div_cancel = 1'b0;
    logic [63:0] product;
    logic        div_end;
    logic        div_busy;

    int errors = 0;
    int checks = 0;
    int cycles;

    div_iter_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .Unsigned   (Unsigned),
        .div_begin  (div_begin),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .div_accept (div_accept),
        .div_cancel (div_cancel),
        .product    (product),
        .div_end    (div_end),
        .div_busy   (div_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic uns, input logic [31:0] a, input logic [31:0] b);
        Unsigned  = uns;
        div_op1   = a;
        div_op2   = b;
        div_begin = 1'b1;
    endtask

    // Counts edges from the edge that samples div_begin-high onwards (bounded).
    task automatic waitEnd(output int n);
        n = 0;
        while (!div_end && n < 40) begin
            tick();
            n++;
            div_begin = 1'b0;
        end
    endtask

    task automatic runDiv(input string tag, input logic uns, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        applyStimulus(uns, a, b);
        waitEnd(n);
        checkOutput({tag, " latency"}, 64'(n), 64'(lat));
        checkOutput({tag, " product"}, product, exp);
        div_accept = 1'b1;
        tick();
        div_accept = 1'b0;
        checkOutput({tag, " end after accept"}, 64'(div_end), 64'd0);
        checkOutput({tag, " busy after accept"}, 64'(div_busy), 64'd0);
    endtask

    initial begin
        #2;
        checkOutput("reset product", product, 64'd0);
        checkOutput("reset end", 64'(div_end), 64'd0);
        checkOutput("reset busy", 64'(div_busy), 64'd0);
        tick();
        resetn = 1'b1;
        tick();

        runDiv("divu 7/2", 1'b1, 32'd7, 32'd2, {32'd1, 32'd3}, 33);
        runDiv("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        runDiv("div 7/-2", 1'b0, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        runDiv("div ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        runDiv("divu x/0", 1'b1, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
        runDiv("div -5/0", 1'b0, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1);
        runDiv("divu max/1", 1'b1, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
        runDiv("divu 5/10", 1'b1, 32'd5, 32'd10, {32'd5, 32'd0}, 33);

        // Held result with delayed accept, then back-to-back start.
        applyStimulus(1'b1, 32'd100, 32'd7);
        waitEnd(cycles);
        checkOutput("hold latency", 64'(cycles), 64'd33);
        applyStimulus(1'b0, 32'd9, 32'd3);
        Unsigned = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("hold end %0d", i), 64'(div_end), 64'd1);
            checkOutput($sformatf("hold product %0d", i), product, {32'd2, 32'd14});
            if (i < 3) tick();
        end
        div_accept = 1'b1;
        tick();
        div_accept = 1'b0;
        checkOutput("b2b idle after accept", 64'(div_end), 64'd0);
        tick();
        checkOutput("b2b busy restart", 64'(div_busy), 64'd1);
        div_begin = 1'b0;
        cycles = 1;
        while (!div_end && cycles < 40) begin
            tick();
            cycles++;
        end
        checkOutput("b2b latency", 64'(cycles), 64'd33);
        checkOutput("b2b product", product, {32'd0, 32'd3});
        div_accept = 1'b1;
        tick();
        div_accept = 1'b0;

        // Cancel mid-BUSY, with a simultaneous begin that must be ignored.
        applyStimulus(1'b1, 32'd50, 32'd4);
        for (int i = 0; i < 11; i++) begin
            tick();
            div_begin = 1'b0;
        end
        checkOutput("busy before cancel", 64'(div_busy), 64'd1);
        div_cancel = 1'b1;
        div_begin  = 1'b1;
        div_op1    = 32'd5;
        div_op2    = 32'd10;
        tick();
        div_cancel = 1'b0;
        checkOutput("cancel busy", 64'(div_busy), 64'd0);
        checkOutput("cancel end", 64'(div_end), 64'd0);
        checkOutput("cancel product", product, {32'd0, 32'd3});
        waitEnd(cycles);
        checkOutput("post-cancel latency", 64'(cycles), 64'd33);
        checkOutput("post-cancel product", product, {32'd5, 32'd0});
        div_accept = 1'b1;
        tick();
        div_accept = 1'b0;

        // Asynchronous reset between edges during BUSY.
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd3);
        for (int i = 0; i < 6; i++) begin
            tick();
            div_begin = 1'b0;
        end
        #2 resetn = 1'b0;
        #1;
        checkOutput("async rst busy", 64'(div_busy), 64'd0);
        checkOutput("async rst end", 64'(div_end), 64'd0);
        checkOutput("async rst product", product, 64'd0);
        tick();
        resetn = 1'b1;
        cycles = 0;
        while (!div_end && cycles < 40) begin
            tick();
            cycles++;
        end
        checkOutput("no stale completion", 64'(div_end), 64'd0);
        runDiv("after reset", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
